pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
Frame-rate game controller that owns all Pong game state. Once per frame it updates paddle positions from player buttons, moves the ball, resolves wall and paddle collisions, keeps score and sequences serve / play / game-over. Its position outputs feed the game renderer directly and stay stable for the whole active video period.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
PADDLE_H, 50, paddle height
BALL_SIZE, 10, ball bounding-box edge
PADDLE_STEP, 4, paddle pixels per frame
BALL_SPEED, 2, ball pixels per frame on each axis
LEFT_FACE_X, 15, rightmost column of the left paddle
RIGHT_FACE_X, 620, leftmost column of the right paddle
SERVE_FRAMES, 60, frames the ball is held centred before play
WIN_SCORE, 9, points needed to win

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
frame_tick  in  1  one-cycle pulse at start of vertical blank
start  in  1  one-cycle pulse that starts or restarts a match
btn_l_up, btn_l_dn, btn_r_up, btn_r_dn  in  1 each  player buttons, already synchronised and level
paddle_left_pos, paddle_right_pos  out  10  paddle top-row y
ball_pos_x, ball_pos_y  out  10  ball top-left corner
score_left, score_right  out  4  points
game_state  out  3  IDLE=0, SERVE=1, PLAY=2, SCORED=3, GAME_OVER=4

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; both paddles 215; ball (315,235); scores 0; serve_dir_x = right; serve_dir_y = down; serve counter 0.
- All registered outputs change only on the clk edge where frame_tick=1. The single exception is the start transitions, which take effect on the start edge.
- IDLE: nothing moves. start -> SERVE, and the serve counter is cleared.
- SERVE: ball held at (315,235). Each tick increments the counter. When the counter reaches SERVE_FRAMES-1 on a tick, the state goes to PLAY and the ball direction is loaded from serve_dir_x and serve_dir_y. serve_dir_y toggles on every serve.
- PLAY: ball moves BALL_SPEED per tick on both axes. All arithmetic uses 11-bit unsigned values with no wrap.
  - Top wall: moving up and y <= BALL_SPEED -> y=0, dir_y flips to down.
  - Bottom wall: moving down and y+BALL_SIZE+BALL_SPEED >= SCREEN_H -> y = SCREEN_H-BALL_SIZE (470), dir_y flips to up.
  - Vertical overlap with a paddle at P: ball_y+BALL_SIZE > P and ball_y < P+PADDLE_H, using pre-move positions.
  - Left paddle hit: moving left, x-BALL_SPEED <= LEFT_FACE_X (computed without underflow) and overlapping the left paddle -> x = LEFT_FACE_X+1 (16), dir_x flips to right.
  - Left miss: moving left, x <= BALL_SPEED and not hit -> score_right+1, serve_dir_x = left, go to SCORED.
  - Right paddle hit: moving right, x+BALL_SIZE+BALL_SPEED >= RIGHT_FACE_X and overlapping the right paddle -> x = RIGHT_FACE_X-BALL_SIZE (610), dir_x flips to left.
  - Right miss: moving right, x+BALL_SIZE+BALL_SPEED >= SCREEN_W and not hit -> score_left+1, serve_dir_x = right, go to SCORED.
  - The paddle-hit check takes priority over the miss check.
  - X and Y collisions resolve independently in the same tick, so a corner hit bounces on both axes.
- SCORED: lasts exactly one tick. The ball is frozen at its last position. On the next tick: if the scorer's score equals WIN_SCORE, go to GAME_OVER; otherwise recentre the ball and go to SERVE.
- GAME_OVER: everything frozen, and paddles do not move. start -> scores 0, ball centred, go to SERVE.
- start is ignored in SERVE, PLAY and SCORED.
- Paddles move only in SERVE and PLAY, once per tick:
  - up only: pos - PADDLE_STEP, saturating at 0.
  - down only: pos + PADDLE_STEP, saturating at SCREEN_H-PADDLE_H (430).
  - both or neither pressed: hold.
  - Paddle motion and ball collision in the same tick use the pre-move paddle positions.
- Scores saturate at 15. This is unreachable when WIN_SCORE <= 15.
- start and frame_tick on the same edge in IDLE: take the transition to SERVE, with no movement on that edge.

Decomposition:
- Package pong_pkg: screen and size constants, the game_state encoding, and the centre-position constants (315, 235, 215).
- One sub-module, pong_paddle_ctrl, instantiated twice. It holds the saturating paddle position register and takes up, down, enable and tick inputs.
- The ball and FSM logic stay in the top level.

Test Plan:
- Reset mid-PLAY: drop rst_n with no clock edge -> outputs read 215/215/315/235, scores 0, game_state=0 immediately.
- Paddle saturation: left paddle at 2 with up held, one tick -> 0. Down held for 120 ticks -> 430. Both held -> no change.
- Top wall: PLAY, ball (300,1) moving up-right, tick -> (302,0) moving down; next tick -> (304,2).
- Left hit: paddle_left=200, ball (17,210) moving left, tick -> x=16 moving right. Repeat with paddle_left=0 -> no hit.
- Miss and serve: paddle_left=0, ball (2,400) moving left, tick -> score_right=1, SCORED; next tick -> SERVE, ball (315,235); after 60 more ticks -> PLAY moving left.
- Win: score_left=8, right miss -> score_left=9, SCORED then GAME_OVER; buttons and ticks change nothing; start -> scores 0, SERVE.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared screen geometry, timing constants and game state encoding for the Pong controller.
package pong_pkg;
  typedef logic [10:0] coord_t;
  localparam coord_t SCREEN_W     = 11'd640;
  localparam coord_t SCREEN_H     = 11'd480;
  localparam coord_t PADDLE_H     = 11'd50;
  localparam coord_t BALL_SIZE    = 11'd10;
  localparam coord_t PADDLE_STEP  = 11'd4;
  localparam coord_t BALL_SPEED   = 11'd2;
  localparam coord_t LEFT_FACE_X  = 11'd15;
  localparam coord_t RIGHT_FACE_X = 11'd620;
  localparam coord_t PADDLE_MAX   = SCREEN_H - PADDLE_H;
  localparam coord_t BALL_Y_MAX   = SCREEN_H - BALL_SIZE;
  localparam coord_t LEFT_X_HIT   = LEFT_FACE_X + 11'd1;
  localparam coord_t RIGHT_X_HIT  = RIGHT_FACE_X - BALL_SIZE;
  localparam logic [9:0] BALL_X0   = 10'd315;
  localparam logic [9:0] BALL_Y0   = 10'd235;
  localparam logic [9:0] PADDLE_Y0 = 10'd215;
  localparam logic [5:0] SERVE_LAST = 6'd59;
  localparam logic [3:0] WIN_SCORE  = 4'd9;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_SCORED    = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_t;
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction
endpackage

// File: rtl/pong_paddle_ctrl.sv
// pong_paddle_ctrl: one paddle's vertical position, stepped once per enabled frame tick and clamped to the screen.
module pong_paddle_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic       i_en,
  input  logic       i_up,
  input  logic       i_dn,
  output logic [9:0] o_pos
);
  logic [9:0] r_pos;
  logic [9:0] w_nxt;
  logic [10:0] w_p;
  logic w_up;
  logic w_dn;
  assign w_p  = {1'b0, r_pos};
  assign w_up = i_tick & i_en & i_up & ~i_dn;
  assign w_dn = i_tick & i_en & i_dn & ~i_up;
  assign w_nxt = w_up ? ((w_p <= PADDLE_STEP) ? '0 : r_pos - PADDLE_STEP[9:0]) :
                 w_dn ? ((w_p + PADDLE_STEP >= PADDLE_MAX) ? PADDLE_MAX[9:0] : r_pos + PADDLE_STEP[9:0]) :
                 r_pos;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pos <= PADDLE_Y0;
    else        r_pos <= w_nxt;
  assign o_pos = r_pos;
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-rate Pong game state: paddles, ball motion and collisions, scoring and serve/play/game-over sequencing.
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       btn_l_up,
  input  logic       btn_l_dn,
  input  logic       btn_r_up,
  input  logic       btn_r_dn,
  output logic [9:0] paddle_left_pos,
  output logic [9:0] paddle_right_pos,
  output logic [9:0] ball_pos_x,
  output logic [9:0] ball_pos_y,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [2:0] game_state
);
  game_state_t r_state, w_state;
  logic [9:0] r_bx, r_by, w_bx, w_by;
  logic r_dx, r_dy, r_sdx, r_sdy, w_dx, w_dy, w_sdx, w_sdy;
  logic [5:0] r_cnt, w_cnt;
  logic [3:0] r_sl, r_sr, w_sl, w_sr;
  logic [9:0] w_pl, w_pr;
  logic [10:0] w_x, w_y, w_pl11, w_pr11;
  logic w_en, w_ovl_l, w_ovl_r;
  logic w_top, w_bot, w_hit_l, w_hit_r, w_miss_l, w_miss_r;
  logic [9:0] w_play_x, w_play_y;
  assign w_en = (r_state == ST_SERVE) || (r_state == ST_PLAY);
  pong_paddle_ctrl u_paddle_l (
    .clk   (clk),
    .rst_n (rst_n),
    .i_tick(frame_tick),
    .i_en  (w_en),
    .i_up  (btn_l_up),
    .i_dn  (btn_l_dn),
    .o_pos (w_pl)
  );
  pong_paddle_ctrl u_paddle_r (
    .clk   (clk),
    .rst_n (rst_n),
    .i_tick(frame_tick),
    .i_en  (w_en),
    .i_up  (btn_r_up),
    .i_dn  (btn_r_dn),
    .o_pos (w_pr)
  );
  // Collision tests see the paddles as they were before this tick's move.
  assign w_x    = {1'b0, r_bx};
  assign w_y    = {1'b0, r_by};
  assign w_pl11 = {1'b0, w_pl};
  assign w_pr11 = {1'b0, w_pr};
  assign w_ovl_l = (w_y + BALL_SIZE > w_pl11) && (w_y < w_pl11 + PADDLE_H);
  assign w_ovl_r = (w_y + BALL_SIZE > w_pr11) && (w_y < w_pr11 + PADDLE_H);
  assign w_top    = !r_dy && (w_y <= BALL_SPEED);
  assign w_bot    =  r_dy && (w_y + BALL_SIZE + BALL_SPEED >= SCREEN_H);
  assign w_hit_l  = !r_dx && (w_x <= LEFT_FACE_X + BALL_SPEED) && w_ovl_l;
  assign w_miss_l = !r_dx && (w_x <= BALL_SPEED) && !w_hit_l;
  assign w_hit_r  =  r_dx && (w_x + BALL_SIZE + BALL_SPEED >= RIGHT_FACE_X) && w_ovl_r;
  assign w_miss_r =  r_dx && (w_x + BALL_SIZE + BALL_SPEED >= SCREEN_W) && !w_hit_r;
  // A missed ball keeps its column so the renderer shows where it left play.
  assign w_play_x = w_hit_l ? LEFT_X_HIT[9:0] :
                    w_hit_r ? RIGHT_X_HIT[9:0] :
                    (w_miss_l || w_miss_r) ? r_bx :
                    r_dx ? r_bx + BALL_SPEED[9:0] : r_bx - BALL_SPEED[9:0];
  assign w_play_y = w_top ? '0 :
                    w_bot ? BALL_Y_MAX[9:0] :
                    r_dy ? r_by + BALL_SPEED[9:0] : r_by - BALL_SPEED[9:0];
  always_comb begin
    w_state = r_state;
    w_bx    = r_bx;
    w_by    = r_by;
    w_dx    = r_dx;
    w_dy    = r_dy;
    w_sdx   = r_sdx;
    w_sdy   = r_sdy;
    w_cnt   = r_cnt;
    w_sl    = r_sl;
    w_sr    = r_sr;
    case (r_state)
      ST_IDLE:
        if (start) begin
          w_state = ST_SERVE;
          w_cnt   = '0;
        end
      ST_SERVE:
        if (frame_tick) begin
          if (r_cnt == SERVE_LAST) begin
            w_state = ST_PLAY;
            w_dx    = r_sdx;
            w_dy    = r_sdy;
            w_sdy   = ~r_sdy;
          end else begin
            w_cnt = r_cnt + 6'd1;
          end
        end
      ST_PLAY:
        if (frame_tick) begin
          w_bx = w_play_x;
          w_by = w_play_y;
          w_dx = w_hit_l | (r_dx & ~w_hit_r);
          w_dy = w_top | (r_dy & ~w_bot);
          if (w_miss_l) begin
            w_sr    = sat_inc(r_sr);
            w_sdx   = 1'b0;
            w_state = ST_SCORED;
          end
          if (w_miss_r) begin
            w_sl    = sat_inc(r_sl);
            w_sdx   = 1'b1;
            w_state = ST_SCORED;
          end
        end
      ST_SCORED:
        if (frame_tick) begin
          if (r_sl == WIN_SCORE || r_sr == WIN_SCORE) begin
            w_state = ST_GAME_OVER;
          end else begin
            w_state = ST_SERVE;
            w_bx    = BALL_X0;
            w_by    = BALL_Y0;
            w_cnt   = '0;
          end
        end
      ST_GAME_OVER:
        if (start) begin
          w_state = ST_SERVE;
          w_sl    = '0;
          w_sr    = '0;
          w_bx    = BALL_X0;
          w_by    = BALL_Y0;
          w_cnt   = '0;
        end
      default: w_state = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_bx    <= BALL_X0;
      r_by    <= BALL_Y0;
      r_dx    <= 1'b1;
      r_dy    <= 1'b1;
      r_sdx   <= 1'b1;
      r_sdy   <= 1'b1;
      r_cnt   <= '0;
      r_sl    <= '0;
      r_sr    <= '0;
    end else begin
      r_state <= w_state;
      r_bx    <= w_bx;
      r_by    <= w_by;
      r_dx    <= w_dx;
      r_dy    <= w_dy;
      r_sdx   <= w_sdx;
      r_sdy   <= w_sdy;
      r_cnt   <= w_cnt;
      r_sl    <= w_sl;
      r_sr    <= w_sr;
    end
  assign paddle_left_pos  = w_pl;
  assign paddle_right_pos = w_pr;
  assign ball_pos_x       = r_bx;
  assign ball_pos_y       = r_by;
  assign score_left       = r_sl;
  assign score_right      = r_sr;
  assign game_state       = r_state;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: random buttons/ticks/starts against an integer game model; expected outputs are queued and compared by a monitor.
module tb_pong_game_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;
  logic start = 1'b0;
  logic btn_l_up = 1'b0;
  logic btn_l_dn = 1'b0;
  logic btn_r_up = 1'b0;
  logic btn_r_dn = 1'b0;
  logic [9:0] paddle_left_pos, paddle_right_pos, ball_pos_x, ball_pos_y;
  logic [3:0] score_left, score_right;
  logic [2:0] game_state;
  pong_game_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .frame_tick      (frame_tick),
    .start           (start),
    .btn_l_up        (btn_l_up),
    .btn_l_dn        (btn_l_dn),
    .btn_r_up        (btn_r_up),
    .btn_r_dn        (btn_r_dn),
    .paddle_left_pos (paddle_left_pos),
    .paddle_right_pos(paddle_right_pos),
    .ball_pos_x      (ball_pos_x),
    .ball_pos_y      (ball_pos_y),
    .score_left      (score_left),
    .score_right     (score_right),
    .game_state      (game_state)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic [50:0] exp_q[$];
  // Game model in plain integers: velocities are signed pixel steps.
  int m_st, m_pl, m_pr, m_bx, m_by, m_vx, m_vy, m_sl, m_sr, m_cnt;
  bit m_serve_right, m_serve_down;
  int n_game_over = 0;
  task automatic model_reset();
    m_st = 0; m_pl = 215; m_pr = 215; m_bx = 315; m_by = 235;
    m_vx = 2; m_vy = 2; m_sl = 0; m_sr = 0; m_cnt = 0;
    m_serve_right = 1'b1; m_serve_down = 1'b1;
  endtask
  function automatic int pad(input int p, input bit u, input bit d);
    if (u && !d) return (p - 4 < 0) ? 0 : p - 4;
    if (d && !u) return (p + 4 > 430) ? 430 : p + 4;
    return p;
  endfunction
  function automatic int inc15(input int s);
    return (s >= 15) ? 15 : s + 1;
  endfunction
  task automatic centre_serve();
    m_bx = 315; m_by = 235; m_st = 1; m_cnt = 0;
  endtask
  task automatic play_tick(input int pl0, input int pr0);
    int nx, ny, nvx, nvy;
    bit ovl, ovr;
    ovl = (m_by + 10 > pl0) && (m_by < pl0 + 50);
    ovr = (m_by + 10 > pr0) && (m_by < pr0 + 50);
    nx = m_bx + m_vx; ny = m_by + m_vy; nvx = m_vx; nvy = m_vy;
    if (m_vy < 0 && ny <= 0) begin ny = 0; nvy = 2; end
    else if (m_vy > 0 && ny + 10 >= 480) begin ny = 470; nvy = -2; end
    if (m_vx < 0) begin
      if (nx <= 15 && ovl) begin nx = 16; nvx = 2; end
      else if (nx <= 0) begin m_sr = inc15(m_sr); m_serve_right = 1'b0; m_st = 3; nx = m_bx; end
    end else begin
      if (nx + 10 >= 620 && ovr) begin nx = 610; nvx = -2; end
      else if (nx + 10 >= 640) begin m_sl = inc15(m_sl); m_serve_right = 1'b1; m_st = 3; nx = m_bx; end
    end
    m_bx = nx; m_by = ny; m_vx = nvx; m_vy = nvy;
  endtask
  task automatic model_step(input bit tk, input bit st, input bit lu, input bit ld, input bit ru, input bit rd);
    int pl0, pr0;
    pl0 = m_pl; pr0 = m_pr;
    if (tk && (m_st == 1 || m_st == 2)) begin
      m_pl = pad(m_pl, lu, ld);
      m_pr = pad(m_pr, ru, rd);
    end
    case (m_st)
      0: if (st) begin m_st = 1; m_cnt = 0; end
      1: if (tk) begin
           if (m_cnt == 59) begin
             m_st = 2;
             m_vx = m_serve_right ? 2 : -2;
             m_vy = m_serve_down ? 2 : -2;
             m_serve_down = !m_serve_down;
           end else m_cnt++;
         end
      2: if (tk) play_tick(pl0, pr0);
      3: if (tk) begin
           if (m_sl == 9 || m_sr == 9) begin m_st = 4; n_game_over++; end
           else centre_serve();
         end
      4: if (st) begin m_sl = 0; m_sr = 0; centre_serve(); end
      default: m_st = 0;
    endcase
  endtask
  function automatic logic [50:0] model_vec();
    return {10'(m_pl), 10'(m_pr), 10'(m_bx), 10'(m_by), 4'(m_sl), 4'(m_sr), 3'(m_st)};
  endfunction
  task automatic check_out(input string name, input logic [50:0] e);
    logic [50:0] g;
    g = {paddle_left_pos, paddle_right_pos, ball_pos_x, ball_pos_y, score_left, score_right, game_state};
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s t=%0t got pl=%0d pr=%0d bx=%0d by=%0d sl=%0d sr=%0d st=%0d expected pl=%0d pr=%0d bx=%0d by=%0d sl=%0d sr=%0d st=%0d",
               name, $time, g[50:41], g[40:31], g[30:21], g[20:11], g[10:7], g[6:3], g[2:0],
               e[50:41], e[40:31], e[30:21], e[20:11], e[10:7], e[6:3], e[2:0]);
    end
  endtask
  task automatic drive(input bit tk, input bit st, input bit lu, input bit ld, input bit ru, input bit rd);
    frame_tick = tk; start = st;
    btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd;
    model_step(tk, st, lu, ld, ru, rd);
    exp_q.push_back(model_vec());
  endtask
  // Monitor: every expected value pushed before an edge is compared just after it.
  initial forever begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) check_out("out", exp_q.pop_front());
  end
  initial begin
    int hold_l, hold_r, pat_l, pat_r, resets;
    hold_l = 0; hold_r = 0; pat_l = 0; pat_r = 0; resets = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check_out("reset", model_vec());
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 44000; cyc++) begin
      @(negedge clk);
      if (resets < 3 && cyc > 12000 * (resets + 1) && m_st == 2) begin
        frame_tick = 1'b0; start = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1 check_out("async_reset", model_vec());
        #1 rst_n = 1'b1;
        resets++;
      end else begin
        if (hold_l == 0) begin pat_l = $urandom_range(0, 3); hold_l = $urandom_range(1, 300); end
        if (hold_r == 0) begin pat_r = $urandom_range(0, 3); hold_r = $urandom_range(1, 300); end
        hold_l--; hold_r--;
        drive(1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0),
              pat_l[0], pat_l[1], pat_r[0], pat_r[1]);
      end
    end
    @(negedge clk);
    frame_tick = 1'b0; start = 1'b0;
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected values never compared, required 0", exp_q.size());
    end
    $display("games completed in model: %0d, async resets: %0d", n_game_over, resets);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
